alu_share_sched: RTL and testbench
==================================

// Module: alu_share_sched
// PURPOSE
//  Round-robin scheduler sharing one N-bit ALU (F-encoded: AND/OR/SUM/SLT, F[2]=invert b/subtract) between two requesters.
//  Accepts one op at a time via valid/ready, registers operands, drives the ALU, waits ALU_LAT cycles, captures Y/c.
//  Returns the result on a single response channel tagged with requester id. Sits between issuing FSMs and the ALU.
// PARAMETERS
//  N        8  operand/result width
//  ALU_LAT  1  cycles from ALU input drive to result capture (>=1; 1 = combinational ALU)
// PORTS
//  clk         in   1    single clock, rising edge
//  rst_n       in   1    asynchronous active-low reset
//  req0_valid  in   1    requester 0 has an op
//  req0_ready  out  1    requester 0 op accepted this cycle when valid&ready
//  req0_a/b    in   N    requester 0 operands
//  req0_f      in   3    requester 0 ALU function
//  req1_*      -    -    identical set for requester 1
//  alu_a/b     out  N    to ALU operands
//  alu_f       out  3    to ALU function
//  alu_y       in   N    from ALU result
//  alu_c       in   1    from ALU carry
//  rsp_valid   out  1    result available
//  rsp_ready   in   1    consumer takes result when valid&ready
//  rsp_id      out  1    requester that issued the op
//  rsp_y       out  N    captured result
//  rsp_c       out  1    captured carry
//  busy        out  1    FSM not in IDLE
// BEHAVIOUR
//  Reset: state=IDLE, prio=0, all outputs 0 (ready, rsp_*, alu_*, busy), wait counter 0.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: reqX_ready asserted combinationally only for the granted requester; grant = prio side if valid, else other side if valid.
//   Handshake: op taken, {a,b,f,id} registered, prio <= ~id, -> EXEC. No valid: stay; both readys 0.
//  EXEC: alu_a/b/f driven from registers, stable throughout; counter counts ALU_LAT cycles.
//   On last cycle, capture alu_y/alu_c into rsp_y/rsp_c, -> RESP.
//  RESP: rsp_valid=1, rsp_id/y/c held stable until rsp_ready; on handshake -> IDLE.
//   rsp_valid is 0 in IDLE and EXEC.
//  Latency (rsp_ready held 1): accept at cycle t; rsp_valid at t+1+ALU_LAT; next accept at t+2+ALU_LAT. No overlap or bypass.
//  Requester ready is 0 in EXEC/RESP; a requester may drop valid before its handshake without effect.
//  alu_* hold the last op's values outside EXEC (no glitching to 0).
//  Simultaneous valid: prio side wins. Alternation is guaranteed when both stay valid.
//  Reset mid-EXEC/RESP: in-flight op discarded, no response emitted, prio=0.
//  ALU_LAT=1: counter unused, EXEC lasts exactly one cycle.
//  Widths: results passed through unmodified; scheduler does no arithmetic.
// STRUCTURE
//  Package alu_sched_pkg: typedef enum logic[1:0] {S_IDLE,S_EXEC,S_RESP}; ALU function localparams
//   F_AND=3'b000, F_OR=3'b001, F_ADD=3'b010, F_SUB=3'b110, F_SLT=3'b111.
//  One natural sub-module: rr_arb2 (2-way round-robin grant + prio flop).
//  ALU itself is external; the bench connects a behavioural ALU model.
// TESTING (N=8)
//  1. req0 a=0x0F b=0x01 f=F_ADD, ALU_LAT=1, rsp_ready=1 -> rsp_valid 2 cycles after accept; rsp_id=0, rsp_y=0x10.
//  2. req0 and req1 valid together with F_SUB a=5,b=7 / F_SLT a=3,b=5 -> responses in order:
//     id0 y=0xFE, then id1 y=0x01. Repeat: order alternates (id1 first).
//  3. rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_y stable, both req ready 0, busy=1; released -> IDLE next cycle.
//  4. ALU_LAT=3, req1 F_OR a=0xA0 b=0x0A -> alu_* stable 3 cycles; rsp_y=0xAA, rsp_id=1, rsp_valid at accept+4.
//  5. rst_n low during EXEC -> rsp_valid stays 0, no response after release; next simultaneous request grants id0.
//  6. req1 valid deasserted before grant while req0 idle -> no handshake; FSM stays IDLE, busy=0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU-sharing scheduler: FSM state encoding and ALU function codes.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // F[2] inverts b and injects carry-in (subtract); F[1:0] selects AND/OR/SUM/SLT.
  localparam logic [2:0] F_AND = 3'b000;
  localparam logic [2:0] F_OR  = 3'b001;
  localparam logic [2:0] F_ADD = 3'b010;
  localparam logic [2:0] F_SUB = 3'b110;
  localparam logic [2:0] F_SLT = 3'b111;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the priority flop points away from the last requester served.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] gnt_o
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (valid_i[prio_q])       gnt_o[prio_q]  = 1'b1;
      else if (valid_i[~prio_q]) gnt_o[~prio_q] = 1'b1;
    end
  end

  assign prio_d = (|gnt_o) ? ~gnt_o[1] : prio_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/alu_share_sched.sv
// Shares one external ALU between two requesters; one op in flight, tagged response.
// state  | meaning
// S_IDLE | waiting for a request, grant offered to one requester
// S_EXEC | operands driven to ALU, counting ALU_LAT cycles
// S_RESP | result held on response channel until consumed
module alu_share_sched
  import alu_sched_pkg::*;
#(
  parameter int N       = 8,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [2:0]   req0_f,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [2:0]   req1_f,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_f,
  input  logic [N-1:0] alu_y,
  input  logic         alu_c,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_y,
  output logic         rsp_c,
  output logic         busy
);

  localparam int            CW       = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_LAT - 1);

  state_e        state_q;
  logic [N-1:0]  a_q, b_q, y_q;
  logic [2:0]    f_q;
  logic          id_q, c_q, rsp_valid_q, busy_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    gnt;
  logic          take, sel;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (state_q == S_IDLE),
    .valid_i ({req1_valid, req0_valid}),
    .gnt_o   (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign take       = |gnt;
  assign sel        = gnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      f_q         <= '0;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      y_q         <= '0;
      c_q         <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (take) begin
            a_q     <= sel ? req1_a : req0_a;
            b_q     <= sel ? req1_b : req0_b;
            f_q     <= sel ? req1_f : req0_f;
            id_q    <= sel;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Terminal count reached on the last ALU_LAT cycle: result is valid now.
          if (cnt_q == '0) begin
            y_q         <= alu_y;
            c_q         <= alu_c;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // Operand registers only change on accept, so the ALU sees the last op outside EXEC.
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_f     = f_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_y     = y_q;
  assign rsp_c     = c_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_share_sched.sv
// Directed bench: a combinational-ALU instance (ALU_LAT=1) and a 3-cycle pipelined-ALU instance.
module tb_alu_share_sched;
  import alu_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r0v, r1v, rspr;
  logic [7:0] r0a, r0b, r1a, r1b;
  logic [2:0] r0f, r1f;

  logic       rdy0_1, rdy1_1, rv1, rid1, rc1, busy1, alu_c1;
  logic [7:0] alu_a1, alu_b1, alu_y1, ry1;
  logic [2:0] alu_f1;
  logic       rdy0_3, rdy1_3, rv3, rid3, rc3, busy3, alu_c3;
  logic [7:0] alu_a3, alu_b3, alu_y3, ry3;
  logic [2:0] alu_f3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [9:0] rq[$];
  logic [8:0] p1 = '0, p2 = '0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] f);
    logic [7:0] bb;
    logic [8:0] s;
    bb = f[2] ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {8'd0, f[2]};
    case (f[1:0])
      2'b00:   return {1'b0, a & bb};
      2'b01:   return {1'b0, a | bb};
      2'b10:   return s;
      default: return {s[8], 7'd0, s[7]};
    endcase
  endfunction

  assign {alu_c1, alu_y1} = alu_fn(alu_a1, alu_b1, alu_f1);
  always @(posedge clk) begin
    p1 <= alu_fn(alu_a3, alu_b3, alu_f3);
    p2 <= p1;
  end
  assign {alu_c3, alu_y3} = p2;

  alu_share_sched #(.N(8), .ALU_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(rdy0_1), .req0_a(r0a), .req0_b(r0b), .req0_f(r0f),
    .req1_valid(r1v), .req1_ready(rdy1_1), .req1_a(r1a), .req1_b(r1b), .req1_f(r1f),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_f(alu_f1), .alu_y(alu_y1), .alu_c(alu_c1),
    .rsp_valid(rv1), .rsp_ready(rspr), .rsp_id(rid1), .rsp_y(ry1), .rsp_c(rc1), .busy(busy1)
  );

  alu_share_sched #(.N(8), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(rdy0_3), .req0_a(r0a), .req0_b(r0b), .req0_f(r0f),
    .req1_valid(r1v), .req1_ready(rdy1_3), .req1_a(r1a), .req1_b(r1b), .req1_f(r1f),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_f(alu_f3), .alu_y(alu_y3), .alu_c(alu_c3),
    .rsp_valid(rv3), .rsp_ready(rspr), .rsp_id(rid3), .rsp_y(ry3), .rsp_c(rc3), .busy(busy3)
  );

  always @(negedge clk)
    if (rst_n && rv1 && rspr) rq.push_back({rid1, rc1, ry1});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with valids set; drops each valid after its handshake.
  task automatic serve(input int nrsp);
    bit d0, d1;
    int budget;
    budget = 40;
    while (rq.size() < nrsp && budget > 0) begin
      #4;
      d0 = r0v && rdy0_1;
      d1 = r1v && rdy1_1;
      @(posedge clk); #1;
      if (d0) r0v = 1'b0;
      if (d1) r1v = 1'b0;
      budget--;
    end
    chk("serve_budget", (budget > 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int acc, lat, nv, nb;
    rst_n = 1'b0; r0v = 1'b0; r1v = 1'b0; rspr = 1'b1;
    r0a = '0; r0b = '0; r0f = '0; r1a = '0; r1b = '0; r1f = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rv1", rv1, 0);     chk("rst_busy1", busy1, 0);
    chk("rst_rdy0", rdy0_1, 0); chk("rst_alu_a1", alu_a1, 0);
    chk("rst_alu_f1", alu_f1, 0); chk("rst_rsp_y1", ry1, 0);
    chk("rst_rid1", rid1, 0);   chk("rst_busy3", busy3, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // basic ADD on requester 0, latency check
    @(posedge clk); #1;
    r0v = 1'b1; r0a = 8'h0F; r0b = 8'h01; r0f = F_ADD;
    #4;
    chk("t1_rdy0", rdy0_1, 1); chk("t1_rdy1", rdy1_1, 0);
    acc = cyc;
    @(posedge clk); #1 r0v = 1'b0;
    #4;
    chk("t1_exec_alu_a", alu_a1, 8'h0F); chk("t1_exec_alu_f", alu_f1, F_ADD);
    chk("t1_exec_busy", busy1, 1);       chk("t1_exec_rv", rv1, 0);
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      if (rv1) begin lat = cyc - acc; break; end
      @(negedge clk);
    end
    chk("t1_lat", lat, 2); chk("t1_id", rid1, 0);
    chk("t1_y", ry1, 8'h10); chk("t1_c", rc1, 0);

    // simultaneous requests, then alternation
    @(posedge clk); #1 rst_n = 1'b0; #2 rst_n = 1'b1;
    rq.delete();
    @(posedge clk); #1;
    r0v = 1'b1; r0a = 8'd5; r0b = 8'd7; r0f = F_SUB;
    r1v = 1'b1; r1a = 8'd3; r1b = 8'd5; r1f = F_SLT;
    serve(2);
    chk("t2_n", rq.size(), 2);
    chk("t2_first", rq[0], {1'b0, 1'b0, 8'hFE});
    chk("t2_second", rq[1], {1'b1, 1'b0, 8'h01});
    rq.delete();
    r0v = 1'b1; r0a = 8'hF0; r0b = 8'h3C; r0f = F_AND;
    serve(1);
    chk("t2_and", rq[0], {1'b0, 1'b0, 8'h30});
    rq.delete();
    r0v = 1'b1; r0a = 8'd5; r0b = 8'd7; r0f = F_SUB;
    r1v = 1'b1; r1a = 8'd3; r1b = 8'd5; r1f = F_SLT;
    serve(2);
    chk("t2_alt_first", rq[0], {1'b1, 1'b0, 8'h01});
    chk("t2_alt_second", rq[1], {1'b0, 1'b0, 8'hFE});

    // response back-pressure
    rq.delete();
    rspr = 1'b0;
    r0v = 1'b1; r0a = 8'h55; r0b = 8'h0F; r0f = F_OR;
    #4 chk("t3_rdy0", rdy0_1, 1);
    @(posedge clk); #1;
    r0a = 8'd1; r0b = 8'd2; r0f = F_ADD;
    r1v = 1'b1; r1a = 8'd3; r1b = 8'd4; r1f = F_ADD;
    #4;
    for (int i = 0; i < 10 && !rv1; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_rv", rv1, 1);       chk("t3_hold_y", ry1, 8'h5F);
      chk("t3_hold_rdy0", rdy0_1, 0);  chk("t3_hold_rdy1", rdy1_1, 0);
      chk("t3_hold_busy", busy1, 1);
      @(negedge clk);
    end
    @(posedge clk); #1 rspr = 1'b1;
    @(posedge clk); #1;
    #4;
    chk("t3_idle_busy", busy1, 0);
    chk("t3_idle_rdy1", rdy1_1, 1);
    chk("t3_idle_rdy0", rdy0_1, 0);
    chk("t3_or", rq[0], {1'b0, 1'b0, 8'h5F});
    @(posedge clk); #1 r1v = 1'b0;
    rq.delete();
    serve(2);
    chk("t3_next_a", rq[0], {1'b1, 1'b0, 8'h07});
    chk("t3_next_b", rq[1], {1'b0, 1'b0, 8'h03});

    // ALU_LAT=3 instance
    @(posedge clk); #1 rst_n = 1'b0; #2 rst_n = 1'b1;
    @(posedge clk); #1;
    r0v = 1'b0; r1v = 1'b1; r1a = 8'hA0; r1b = 8'h0A; r1f = F_OR;
    #4 chk("t4_rdy1", rdy1_3, 1);
    @(posedge clk); #1 r1v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("t4_alu_a", alu_a3, 8'hA0); chk("t4_alu_b", alu_b3, 8'h0A);
      chk("t4_alu_f", alu_f3, F_OR);  chk("t4_exec_rv", rv3, 0);
      @(posedge clk); #1;
    end
    #4;
    chk("t4_rv", rv3, 1);    chk("t4_y", ry3, 8'hAA);
    chk("t4_id", rid3, 1);   chk("t4_alu_hold", alu_a3, 8'hA0);

    // reset during EXEC
    @(posedge clk); #1;
    r0v = 1'b1; r0a = 8'd1; r0b = 8'd1; r0f = F_ADD;
    #4 chk("t5_rdy0", rdy0_3, 1);
    @(posedge clk); #1 r0v = 1'b0;
    #1 rst_n = 1'b0; #2 rst_n = 1'b1;
    nv = 0;
    repeat (8) begin
      @(negedge clk);
      if (rv3) nv++;
    end
    chk("t5_no_rsp", nv, 0);
    chk("t5_busy", busy3, 0);
    @(posedge clk); #1;
    r0v = 1'b1; r1v = 1'b1;
    #4;
    chk("t5_prio_rdy0", rdy0_3, 1);
    chk("t5_prio_rdy1", rdy1_3, 0);
    @(posedge clk); #1 r0v = 1'b0; r1v = 1'b0;
    repeat (8) @(posedge clk);

    // requester 1 withdraws while scheduler is busy
    #1;
    rspr = 1'b0; rq.delete();
    r0v = 1'b1; r0a = 8'hFF; r0b = 8'h0F; r0f = F_AND;
    #4 chk("t6_rdy0", rdy0_1, 1);
    @(posedge clk); #1;
    r0v = 1'b0; r1v = 1'b1; r1a = 8'h11; r1b = 8'h22; r1f = F_ADD;
    #4 chk("t6_exec_rdy1", rdy1_1, 0);
    @(posedge clk); #1;
    #4;
    chk("t6_resp_rdy1", rdy1_1, 0);
    chk("t6_resp_rv", rv1, 1);
    @(posedge clk); #1;
    r1v = 1'b0; rspr = 1'b1;
    #4 chk("t6_resp_rv2", rv1, 1);
    nv = 0; nb = 0;
    repeat (5) begin
      @(negedge clk);
      if (rv1) nv++;
      if (busy1) nb++;
      if (rdy1_1) nb++;
    end
    chk("t6_no_rsp", nv, 0);
    chk("t6_idle", nb, 0);
    chk("t6_n", rq.size(), 1);
    chk("t6_y", rq[0], {1'b0, 1'b0, 8'h0F});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
